// File: rtl/uart_rx_frame_ctrl.sv
// Frame controller behind uart_rx: header/addr/data[/checksum] -> write strobe.
// Optional macro FRAME_CHECKSUM_EN adds a trailing XOR checksum byte (4-byte frame).
module uart_rx_frame_ctrl #(
    parameter int          p_clkfreq    = 100_000_000,
    parameter int          p_timeout_us = 1000,
    parameter logic [7:0]  p_header     = 8'hA5
) (
    input  logic       clk,
    input  logic       rst_i,
    input  logic [7:0] din_i,
    input  logic       rx_done_tick_i,
    output logic       wr_en_o,
    output logic [7:0] wr_addr_o,
    output logic [7:0] wr_data_o,
    output logic       busy_o,
    output logic       frame_err_o,
    output logic [7:0] err_cnt_o
);

    localparam int c_timeout = (p_clkfreq / 1_000_000) * p_timeout_us;
    localparam int c_cnt_w   = $clog2(c_timeout + 1);
    localparam logic [c_cnt_w-1:0] c_expire = c_cnt_w'(c_timeout - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ADDR,
        S_DATA,
        S_CHK
    } state_t;

    state_t             state_q, state_d;
    logic [c_cnt_w-1:0] cnt_q, cnt_d;
    logic [7:0]         addr_q, addr_d;
`ifdef FRAME_CHECKSUM_EN
    logic [7:0]         data_q, data_d;
    logic [7:0]         chk_q, chk_d;
`endif
    logic               wr_en_d;
    logic [7:0]         wr_addr_d;
    logic [7:0]         wr_data_d;
    logic               err_d;
    logic [7:0]         err_cnt_d;
    logic               expire;

    assign busy_o = (state_q != S_IDLE);

    // Next-state, byte capture, inter-byte timeout and output strobes
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + 1'b1;
        addr_d    = addr_q;
`ifdef FRAME_CHECKSUM_EN
        data_d    = data_q;
        chk_d     = chk_q;
`endif
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_o;
        wr_data_d = wr_data_o;
        err_d     = 1'b0;

        expire = (state_q != S_IDLE) && !rx_done_tick_i
                 && (cnt_q == c_expire);

        if (state_q == S_IDLE || rx_done_tick_i || expire) begin
            cnt_d = '0;
        end

        if (expire) begin
            // A stalled frame is dropped; a tick in this cycle would win
            state_d = S_IDLE;
            err_d   = 1'b1;
        end else if (rx_done_tick_i) begin
            unique case (state_q)
                S_IDLE: begin
                    if (din_i == p_header) begin
                        state_d = S_ADDR;
`ifdef FRAME_CHECKSUM_EN
                        chk_d   = p_header;
`endif
                    end
                end
                S_ADDR: begin
                    addr_d  = din_i;
                    state_d = S_DATA;
`ifdef FRAME_CHECKSUM_EN
                    chk_d   = chk_q ^ din_i;
`endif
                end
                S_DATA: begin
`ifdef FRAME_CHECKSUM_EN
                    data_d  = din_i;
                    chk_d   = chk_q ^ din_i;
                    state_d = S_CHK;
`else
                    wr_en_d   = 1'b1;
                    wr_addr_d = addr_q;
                    wr_data_d = din_i;
                    state_d   = S_IDLE;
`endif
                end
                S_CHK: begin
`ifdef FRAME_CHECKSUM_EN
                    if (din_i == chk_q) begin
                        wr_en_d   = 1'b1;
                        wr_addr_d = addr_q;
                        wr_data_d = data_q;
                    end else begin
                        err_d = 1'b1;
                    end
`endif
                    state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end

        err_cnt_d = err_cnt_o;
        if (err_d && err_cnt_o != 8'hFF) begin
            err_cnt_d = err_cnt_o + 8'd1;
        end
    end

    // State, datapath and registered outputs
    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            addr_q      <= 8'h00;
`ifdef FRAME_CHECKSUM_EN
            data_q      <= 8'h00;
            chk_q       <= 8'h00;
`endif
            wr_en_o     <= 1'b0;
            wr_addr_o   <= 8'h00;
            wr_data_o   <= 8'h00;
            frame_err_o <= 1'b0;
            err_cnt_o   <= 8'h00;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
`ifdef FRAME_CHECKSUM_EN
            data_q      <= data_d;
            chk_q       <= chk_d;
`endif
            wr_en_o     <= wr_en_d;
            wr_addr_o   <= wr_addr_d;
            wr_data_o   <= wr_data_d;
            frame_err_o <= err_d;
            err_cnt_o   <= err_cnt_d;
        end
    end

endmodule
